testdrive_event_gen: RTL

Programmable interrupt and busy event source for the testdrive simulation top. It sits directly upstream of the interrupt BFM and the busy BFM and drives their `INTR` and `BUSY` inputs, which are otherwise tied to 0. Host-side DPI code or a bench sequencer issues a command: generate N interrupt events spaced P clocks apart. Each event is held until acknowledged, and `BUSY` keeps the simulation running until the sequence completes or is aborted.

---
 rtl/testdrive_event_pkg.sv | 26 ++
 rtl/testdrive_event_counter.sv | 48 ++++
 rtl/testdrive_event_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/testdrive_event_pkg.sv
// testdrive_event_pkg
//   Shared types and helpers for the testdrive interrupt/busy event source.
//   - event_state_t : FSM state encoding (IDLE, COUNT, PEND)
//   - eff_period()  : maps a requested period of 0 to 1 so every event is
//                     separated by at least one inactive INTR clock
package testdrive_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2
  } event_state_t;

  // Period values are carried at 32 bits through the helper. Callers
  // zero-extend into it and cast the result back to their own width.
  function automatic logic [31:0] eff_period(input logic [31:0] period);
    logic [31:0] result;
    if (period == 32'd0) begin
      result = 32'd1;
    end else begin
      result = period;
    end
    return result;
  endfunction

endpackage

// File: rtl/testdrive_event_counter.sv
// testdrive_event_counter
//   Loadable down-counter used as the period timer.
//   Ports:
//     clk_i     : clock
//     rst_n_i   : asynchronous active-low reset (counter clears to 0)
//     load_i    : load value_i this clock (has priority over en_i)
//     value_i   : value to load
//     en_i      : decrement this clock; the counter stops at 0, never wraps
//     expire_o  : high while the registered count equals 1, i.e. the
//                 owner should act on the next edge
module testdrive_event_counter #(
  parameter int unsigned C_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [C_WIDTH-1:0] value_i,
  input  logic               en_i,
  output logic               expire_o
);

  logic [C_WIDTH-1:0] count_q;
  logic [C_WIDTH-1:0] count_d;

  // Next-count selection: load, decrement (saturating at 0) or hold
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i && (count_q != {C_WIDTH{1'b0}})) begin
      count_d = count_q - C_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= {C_WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == C_WIDTH'(1));

endmodule

// File: rtl/testdrive_event_gen.sv
// testdrive_event_gen
//   Programmable interrupt/busy event source feeding the interrupt and busy
//   BFMs. A command requests CMD_COUNT interrupt events, each raised
//   CMD_PERIOD clocks after the previous arm and held until acknowledged.
//   Ports:
//     CLK, nRST              : clock, asynchronous active-low reset
//     CMD_VALID / CMD_READY  : command handshake (ready only in IDLE and
//                              not while CMD_ABORT is high)
//     CMD_PERIOD, CMD_COUNT  : command fields, latched on acceptance
//     CMD_ABORT              : drop the running sequence (no DONE)
//     INTR_ACK               : acknowledge of the pending interrupt
//     INTR                   : interrupt level, polarity from C_INTR_ACTIVE
//     BUSY                   : high while a sequence is running
//     EVT_CNT                : events acknowledged in current/last sequence
//     DONE                   : one-cycle pulse on normal completion
module testdrive_event_gen
  import testdrive_event_pkg::*;
#(
  parameter int unsigned C_PERIOD_WIDTH = 16,
  parameter int unsigned C_COUNT_WIDTH  = 8,
  parameter bit          C_INTR_ACTIVE  = 1'b1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [C_PERIOD_WIDTH-1:0] CMD_PERIOD,
  input  logic [C_COUNT_WIDTH-1:0]  CMD_COUNT,
  input  logic                      CMD_ABORT,
  input  logic                      INTR_ACK,
  output logic                      INTR,
  output logic                      BUSY,
  output logic [C_COUNT_WIDTH-1:0]  EVT_CNT,
  output logic                      DONE
);

  localparam logic INTR_ON = C_INTR_ACTIVE;

  event_state_t              state_q,   state_d;
  logic [C_PERIOD_WIDTH-1:0] period_q,  period_d;
  logic [C_COUNT_WIDTH-1:0]  remain_q,  remain_d;
  logic [C_COUNT_WIDTH-1:0]  evt_cnt_q, evt_cnt_d;
  logic                      done_q,    done_d;

  logic                      accept_s;
  logic [C_PERIOD_WIDTH-1:0] cmd_period_eff_s;
  logic                      tmr_load_s;
  logic [C_PERIOD_WIDTH-1:0] tmr_value_s;
  logic                      tmr_en_s;
  logic                      tmr_expire_s;

  assign cmd_period_eff_s = C_PERIOD_WIDTH'(eff_period(32'(CMD_PERIOD)));

  // Abort is the only input allowed to reach an output combinationally.
  assign CMD_READY = (state_q == IDLE) && !CMD_ABORT;
  assign accept_s  = CMD_READY && CMD_VALID;

  testdrive_event_counter #(
    .C_WIDTH (C_PERIOD_WIDTH)
  ) u_period_timer (
    .clk_i    (CLK),
    .rst_n_i  (nRST),
    .load_i   (tmr_load_s),
    .value_i  (tmr_value_s),
    .en_i     (tmr_en_s),
    .expire_o (tmr_expire_s)
  );

  // Sequencer: next state, count registers and period-timer control
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    remain_d    = remain_q;
    evt_cnt_d   = evt_cnt_q;
    done_d      = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_value_s = period_q;
    tmr_en_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          period_d  = cmd_period_eff_s;
          remain_d  = CMD_COUNT;
          evt_cnt_d = {C_COUNT_WIDTH{1'b0}};
          if (CMD_COUNT != {C_COUNT_WIDTH{1'b0}}) begin
            state_d     = COUNT;
            tmr_load_s  = 1'b1;
            tmr_value_s = cmd_period_eff_s;
          end else begin
            // Empty sequence: report completion without ever going busy.
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      COUNT: begin
        if (CMD_ABORT) begin
          state_d = IDLE;
        end else begin
          tmr_en_s = 1'b1;
          // Count of 1 now means INTR must be active from the next edge.
          if (tmr_expire_s) begin
            state_d = PEND;
          end else begin
            state_d = COUNT;
          end
        end
      end

      PEND: begin
        if (CMD_ABORT) begin
          // Abort wins over a simultaneous acknowledge: nothing is counted.
          state_d = IDLE;
        end else if (INTR_ACK) begin
          evt_cnt_d = evt_cnt_q + C_COUNT_WIDTH'(1);
          remain_d  = remain_q - C_COUNT_WIDTH'(1);
          if (remain_q == C_COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = COUNT;
            tmr_load_s  = 1'b1;
            tmr_value_s = period_q;
          end
        end else begin
          state_d = PEND;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and count registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      period_q  <= {C_PERIOD_WIDTH{1'b0}};
      remain_q  <= {C_COUNT_WIDTH{1'b0}};
      evt_cnt_q <= {C_COUNT_WIDTH{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      remain_q  <= remain_d;
      evt_cnt_q <= evt_cnt_d;
      done_q    <= done_d;
    end
  end

  assign INTR    = (state_q == PEND) ? INTR_ON : ~INTR_ON;
  assign BUSY    = (state_q != IDLE);
  assign EVT_CNT = evt_cnt_q;
  assign DONE    = done_q;

endmodule
